// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped one-word-per-line instruction cache controller
// Optional hit/miss statistics counters: define ICACHE_STATS_EN.
module icache_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                                clka,
  input  logic                                rsta,
  input  logic                                cpu_req_valid,
  output logic                                cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0]               cpu_req_addr,
  output logic                                cpu_resp_valid,
  output logic [DATA_WIDTH-1:0]               cpu_resp_data,
  input  logic                                flush,
  output logic                                tag_en,
  output logic                                tag_we,
  output logic [INDEX_WIDTH-1:0]              tag_addr,
  output logic [ADDR_WIDTH-INDEX_WIDTH-3:0]   tag_din,
  input  logic [ADDR_WIDTH-INDEX_WIDTH-3:0]   tag_dout,
  output logic                                dat_en,
  output logic                                dat_we,
  output logic [INDEX_WIDTH-1:0]              dat_addr,
  output logic [DATA_WIDTH-1:0]               dat_din,
  input  logic [DATA_WIDTH-1:0]               dat_dout,
  output logic                                mem_req,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  input  logic                                mem_rvalid,
  input  logic [DATA_WIDTH-1:0]               mem_rdata,
  output logic [31:0]                         stat_hits,
  output logic [31:0]                         stat_misses
);

  localparam int TAG_W  = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int NLINES = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL} state_t;

  state_t                   r_state, w_state_nxt;
  logic [NLINES-1:0]        r_valid;
  logic                     r_flush_pend;
  logic [TAG_W-1:0]         r_tag;
  logic [INDEX_WIDTH-1:0]   r_idx;
  logic [DATA_WIDTH-1:0]    r_word;

  logic [INDEX_WIDTH-1:0]   w_req_idx;
  logic [TAG_W-1:0]         w_req_tag;
  logic                     w_hit;
  logic                     w_accept;
  logic                     w_flush_clr;
  logic                     w_lookup_hit;
  logic                     w_lookup_miss;
  logic                     w_unused_addr_bits;

  assign w_req_idx          = cpu_req_addr[INDEX_WIDTH+1:2];
  assign w_req_tag          = cpu_req_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign w_hit              = r_valid[r_idx] && (tag_dout == r_tag);
  assign w_unused_addr_bits = ^cpu_req_addr[1:0];

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_data  = '0;
    tag_en         = 1'b0;
    tag_we         = 1'b0;
    tag_addr       = '0;
    tag_din        = '0;
    dat_en         = 1'b0;
    dat_we         = 1'b0;
    dat_addr       = '0;
    dat_din        = '0;
    mem_req        = 1'b0;
    mem_addr       = '0;
    w_accept       = 1'b0;
    w_flush_clr    = 1'b0;
    w_lookup_hit   = 1'b0;
    w_lookup_miss  = 1'b0;
    case (r_state)
      S_IDLE: begin
        cpu_req_ready = !r_flush_pend;
        w_flush_clr   = r_flush_pend;
        if (cpu_req_valid && !r_flush_pend) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_lookup_hit   = 1'b1;
          cpu_resp_valid = 1'b1;
          cpu_resp_data  = dat_dout;
          cpu_req_ready  = !r_flush_pend;
          // A new request in the hit cycle keeps the pipeline streaming.
          if (cpu_req_valid && !r_flush_pend) begin
            w_accept = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_flush_clr = r_flush_pend;
          end
        end else begin
          w_lookup_miss = 1'b1;
          w_state_nxt   = S_MISS;
        end
      end
      S_MISS: begin
        mem_req  = 1'b1;
        mem_addr = {r_tag, r_idx, 2'b00};
        if (mem_rvalid) w_state_nxt = S_REFILL;
      end
      S_REFILL: begin
        tag_en         = 1'b1;
        tag_we         = 1'b1;
        tag_addr       = r_idx;
        tag_din        = r_tag;
        dat_en         = 1'b1;
        dat_we         = 1'b1;
        dat_addr       = r_idx;
        dat_din        = r_word;
        cpu_resp_valid = 1'b1;
        cpu_resp_data  = r_word;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_accept) begin
      tag_en   = 1'b1;
      dat_en   = 1'b1;
      tag_addr = w_req_idx;
      dat_addr = w_req_idx;
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_word       <= '0;
    end else begin
      if (w_accept) begin
        r_tag <= w_req_tag;
        r_idx <= w_req_idx;
      end
      if (r_state == S_MISS && mem_rvalid) r_word <= mem_rdata;
      // A refill never coincides with a flush clear, so the refilled line is dropped one cycle later.
      if (w_flush_clr)               r_valid        <= '0;
      else if (r_state == S_REFILL)  r_valid[r_idx] <= 1'b1;
      r_flush_pend <= flush | (r_flush_pend & !w_flush_clr);
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      if (w_lookup_hit && r_hits != 32'hFFFF_FFFF)    r_hits   <= r_hits + 32'd1;
      if (w_lookup_miss && r_misses != 32'hFFFF_FFFF) r_misses <= r_misses + 32'd1;
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
`else
  assign stat_hits   = 32'd0;
  assign stat_misses = 32'd0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - self-checking bench for icache_ctrl with macro and memory models
module tb_icache_ctrl;

  logic        clka = 1'b0;
  logic        rsta = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic [31:0] cpu_req_addr = '0;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic        flush = 1'b0;
  logic        tag_en, tag_we, dat_en, dat_we;
  logic [5:0]  tag_addr, dat_addr;
  logic [23:0] tag_din;
  logic [23:0] tag_dout = '0;
  logic [31:0] dat_din;
  logic [31:0] dat_dout = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] stat_hits, stat_misses;

  icache_ctrl dut (
    .clka(clka), .rsta(rsta),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .flush(flush),
    .tag_en(tag_en), .tag_we(tag_we), .tag_addr(tag_addr), .tag_din(tag_din), .tag_dout(tag_dout),
    .dat_en(dat_en), .dat_we(dat_we), .dat_addr(dat_addr), .dat_din(dat_din), .dat_dout(dat_dout),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clka = ~clka;

  // Macro models: stale, untrusted contents (tag 0 everywhere) after power-up.
  logic [23:0] tag_mem [64] = '{default: 24'h0};
  logic [31:0] dat_mem [64] = '{default: 32'h5A5A_5A5A};

  always @(posedge clka) begin
    if (tag_en) begin
      if (tag_we) tag_mem[tag_addr] <= tag_din;
      else        tag_dout <= tag_mem[tag_addr];
    end
    if (dat_en) begin
      if (dat_we) dat_mem[dat_addr] <= dat_din;
      else        dat_dout <= dat_mem[dat_addr];
    end
  end

  logic [31:0] ovr [logic [31:0]];

  function automatic logic [31:0] memword(input logic [31:0] wa);
    if (ovr.exists(wa)) return ovr[wa];
    return wa * 32'h9E37_79B1 + 32'h1357_2468;
  endfunction

  bit resp_en = 1'b1;
  int inject_req = 0;
  int inject_done = 0;
  int lat = 0;

  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clka);
      if (mem_rvalid) begin
        mem_rvalid = 1'b0;
      end else if (inject_req != inject_done) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        inject_done++;
      end else if (resp_en && mem_req) begin
        if (lat == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = memword(mem_addr);
          lat        = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end
    end
  end

  // Reference model: which line holds which tag, and lookup tallies.
  bit          ref_valid [64];
  logic [23:0] ref_tag [64];
  int          h_cnt = 0;
  int          m_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic void ref_flush();
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
  endfunction

  function automatic logic [31:0] exp_hits();
`ifdef ICACHE_STATS_EN
    return h_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_misses();
`ifdef ICACHE_STATS_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input bit flush_mid);
    int          n;
    bit          seen_req;
    bit          did_flush;
    bit          exp_hit;
    logic [5:0]  ix;
    logic [23:0] tg;
    logic [31:0] exp_data;
    ix       = a[7:2];
    tg       = a[31:8];
    exp_hit  = ref_valid[ix] && ref_tag[ix] == tg;
    exp_data = memword({a[31:2], 2'b00});
    @(negedge clka);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    #1;
    n = 0;
    while (!cpu_req_ready && n < 50) begin
      @(negedge clka);
      #1;
      n++;
    end
    chk("accept_timeout", n < 50, 1);
    @(negedge clka);
    cpu_req_valid = 1'b0;
    cpu_req_addr  = $urandom;
    n = 1;
    seen_req  = 1'b0;
    did_flush = 1'b0;
    while (!cpu_resp_valid && n < 50) begin
      if (mem_req && !seen_req) begin
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        seen_req = 1'b1;
        if (flush_mid) begin
          flush     = 1'b1;
          did_flush = 1'b1;
        end
      end
      @(negedge clka);
      flush = 1'b0;
      n++;
    end
    chk("resp_seen", cpu_resp_valid, 1);
    chk("resp_data", cpu_resp_data, exp_data);
    chk("miss_seen", seen_req, !exp_hit);
    if (exp_hit) begin
      chk("hit_latency", n, 1);
      chk("hit_no_write", {tag_we, dat_we}, 2'b00);
    end else begin
      chk("miss_latency_min", n >= 3, 1);
      chk("refill_write", {tag_we, dat_we, tag_addr, tag_din}, {2'b11, ix, tg});
    end
    if (exp_hit) begin
      h_cnt++;
    end else begin
      m_cnt++;
      ref_valid[ix] = 1'b1;
      ref_tag[ix]   = tg;
    end
    if (did_flush) ref_flush();
  endtask

  task automatic pulse_flush();
    @(negedge clka);
    flush = 1'b1;
    @(negedge clka);
    flush = 1'b0;
    ref_flush();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          n;
    ref_flush();
    ovr[32'h0000_0104] = 32'hDEAD_BEEF;
    ovr[32'h0000_0204] = 32'h1234_5678;

    repeat (2) @(posedge clka);
    #1;
    chk("reset_ctrl_outs", {cpu_req_ready, cpu_resp_valid, mem_req, tag_en, dat_en, tag_we, dat_we}, 7'b100_0000);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_stats", {stat_hits, stat_misses}, 64'd0);
    @(negedge clka);
    rsta = 1'b0;

    fetch(32'h0000_0104, 1'b0);

    // Back-to-back streaming hits on 0x104.
    @(negedge clka);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h0000_0104;
    #1;
    chk("stream_ready0", cpu_req_ready, 1);
    @(negedge clka);
    chk("stream_resp1", {cpu_resp_valid, cpu_resp_data}, {1'b1, 32'hDEAD_BEEF});
    chk("stream_ready1", cpu_req_ready, 1);
    @(negedge clka);
    cpu_req_valid = 1'b0;
    chk("stream_resp2", {cpu_resp_valid, cpu_resp_data}, {1'b1, 32'hDEAD_BEEF});
    chk("stream_no_memreq", mem_req, 0);
    h_cnt += 2;
    @(negedge clka);
    chk("stream_idle", cpu_resp_valid, 0);

    fetch(32'h0000_0204, 1'b0);
    fetch(32'h0000_0104, 1'b0);
    chk("stats_hits_directed", stat_hits, exp_hits());
    chk("stats_misses_directed", stat_misses, exp_misses());

    // Flush during a miss: refill still delivers, then the line is gone.
    fetch(32'h0000_0108, 1'b1);
    fetch(32'h0000_0108, 1'b0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        pulse_flush();
      end else begin
        a = {22'd0, 2'($urandom_range(0, 3)), 3'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
        fetch(a, $urandom_range(0, 24) == 0);
      end
    end
    chk("stats_hits_random", stat_hits, exp_hits());
    chk("stats_misses_random", stat_misses, exp_misses());

    // Reset in the middle of a miss.
    pulse_flush();
    resp_en = 1'b0;
    @(negedge clka);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h0000_0300;
    #1;
    n = 0;
    while (!cpu_req_ready && n < 50) begin
      @(negedge clka);
      #1;
      n++;
    end
    chk("rst_accept_timeout", n < 50, 1);
    @(negedge clka);
    cpu_req_valid = 1'b0;
    @(negedge clka);
    chk("rst_in_miss", mem_req, 1);
    #2;
    rsta = 1'b1;
    #1;
    chk("rst_memreq_async", mem_req, 0);
    chk("rst_ready", cpu_req_ready, 1);
    @(negedge clka);
    rsta = 1'b0;
    inject_req++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clka);
      chk("late_rvalid_ignored", {cpu_resp_valid, mem_req, tag_we}, 3'b000);
    end
    ref_flush();
    h_cnt = 0;
    m_cnt = 0;
    chk("stats_after_reset", {stat_hits, stat_misses}, 64'd0);
    resp_en = 1'b1;
    fetch(32'h0000_0300, 1'b0);
    chk("stats_hits_final", stat_hits, exp_hits());
    chk("stats_misses_final", stat_misses, exp_misses());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
